// File: rtl/fpga_robots_game_ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state codes, frame width
// and the odd-parity rule used to accept a frame.
package fpga_robots_game_ps2_pkg;

    localparam int unsigned PS2_DATA_BITS = 8;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
    localparam logic PS2_PARITY_ODD = 1'b1;

    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return (^{data, par}) == PS2_PARITY_ODD;
    endfunction

endpackage

// File: rtl/fpga_robots_game_ps2_filter.sv
// Two-flop synchronizer plus glitch filter for the PS/2 clock line; emits a
// one-cycle strobe in the cycle the filtered clock falls.
module fpga_robots_game_ps2_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    output logic fall_o
);

    localparam logic [7:0] FILT_TC = 8'(FILTER_LEN - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q,  filt_d;
    logic [7:0] cnt_q,   cnt_d;

    // The counter tracks how many consecutive samples disagree with the filtered level.
    always_comb begin
        sync1_d = ps2_clk;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        fall_o  = 1'b0;
        if (sync2_q != filt_q) begin
            if (cnt_q == FILT_TC) begin
                filt_d = sync2_q;
                fall_o = filt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/fpga_robots_game_ps2_rx.sv
// Receive-only PS/2 frame decoder (start, 8 data LSB first, odd parity, stop).
// Define FPGA_ROBOTS_PS2_WATCHDOG_EN to abandon frames stalled for TIMEOUT_CYC cycles.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (0) on a filtered clock fall
// ST_DATA   | shifting in the 8 data bits, LSB first
// ST_PARITY | capturing the parity bit and recording the odd-parity check
// ST_STOP   | checking the stop bit; publish byte or flag error
module fpga_robots_game_ps2_rx
    import fpga_robots_game_ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_rx_dat,
    output logic       ps2_rx_stb,
    output logic       ps2_rx_err
);

    localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic                     clk_fall;
    logic                     timeout;
    logic                     dat_s1_q, dat_s1_d;
    logic                     dat_s2_q, dat_s2_d;
    ps2_state_t               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_ok_q, par_ok_d;
    logic [PS2_DATA_BITS-1:0] rx_dat_q, rx_dat_d;
    logic                     stb_q, stb_d;
    logic                     err_q, err_d;

    fpga_robots_game_ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .fall_o  (clk_fall)
    );

`ifdef FPGA_ROBOTS_PS2_WATCHDOG_EN
    localparam logic [31:0] WD_TC = 32'(TIMEOUT_CYC);

    logic [31:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q + 32'd1;
        if (state_q == ST_IDLE || clk_fall || timeout) begin
            wd_d = '0;
        end
    end

    assign timeout = (state_q != ST_IDLE) && (wd_q == WD_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        dat_s1_d  = ps2_dat;
        dat_s2_d  = dat_s1_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        rx_dat_d  = rx_dat_q;
        stb_d     = 1'b0;
        err_d     = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (clk_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ps2_parity_ok(shift_q, dat_s2_q);
                    state_d  = ST_STOP;
                end
                default: begin
                    if (dat_s2_q && par_ok_q) begin
                        rx_dat_d = shift_q;
                        stb_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            rx_dat_q  <= '0;
            stb_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            rx_dat_q  <= rx_dat_d;
            stb_q     <= stb_d;
            err_q     <= err_d;
        end
    end

    assign ps2_rx_dat = rx_dat_q;
    assign ps2_rx_stb = stb_q;
    assign ps2_rx_err = err_q;

endmodule

// File: tb/tb_fpga_robots_game_ps2_rx.sv
// Self-checking bench for fpga_robots_game_ps2_rx: frame-level reference model
// compared every cycle, plus literal checks on directed and random frames.
module tb_fpga_robots_game_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 1500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;

    always #5 clk = ~clk;

    fpga_robots_game_ps2_rx #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .ps2_rx_dat (rx_dat),
        .ps2_rx_stb (rx_stb),
        .ps2_rx_err (rx_err)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         ms1 = 1, ms2 = 1, md1 = 1, md2 = 1, mfilt = 1;
    bit         win[$];
    bit         mbits[$];
    int         since = 0;
    int         ones;
    bit         m_fall, m_timeout;
    logic [7:0] mbyte;
    logic [7:0] exp_dat = 8'h00;
    logic       exp_stb = 1'b0;
    logic       exp_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ms1 = 1; ms2 = 1; md1 = 1; md2 = 1; mfilt = 1;
            win.delete();
            mbits.delete();
            since   = 0;
            exp_dat = 8'h00;
            exp_stb = 1'b0;
            exp_err = 1'b0;
        end else begin
            win.push_back(ms2);
            if (win.size() > FL) void'(win.pop_front());
            m_fall = 0;
            if (win.size() == FL) begin
                ones = 0;
                foreach (win[i]) ones += int'(win[i]);
                if (mfilt && ones == 0) begin
                    mfilt  = 0;
                    m_fall = 1;
                end else if (!mfilt && ones == FL) begin
                    mfilt = 1;
                end
            end
            exp_stb   = 1'b0;
            exp_err   = 1'b0;
            m_timeout = 0;
            since++;
`ifdef FPGA_ROBOTS_PS2_WATCHDOG_EN
            if (mbits.size() > 0 && since == TO + 1) begin
                m_timeout = 1;
                exp_err   = 1'b1;
                mbits.delete();
            end
`endif
            if (m_fall && !m_timeout) begin
                if (mbits.size() > 0 || md2 == 0) mbits.push_back(md2);
                if (mbits.size() == 11) begin
                    for (int i = 0; i < 8; i++) mbyte[i] = mbits[1 + i];
                    if (mbits[10] && ((^mbyte) ^ mbits[9])) begin
                        exp_stb = 1'b1;
                        exp_dat = mbyte;
                    end else begin
                        exp_err = 1'b1;
                    end
                    mbits.delete();
                end
            end
            if (m_fall) since = 0;
            ms2 = ms1; ms1 = ps2_clk;
            md2 = md1; md1 = ps2_dat;
        end
    end

    // ---------------- per-cycle compare and event counters ----------------
    int         n_stb = 0;
    int         n_errp = 0;
    logic [7:0] last_stb = 8'h00;

    always @(negedge clk) begin
        check("stb", rx_stb, exp_stb);
        check("err", rx_err, exp_err);
        check("dat", rx_dat, exp_dat);
        if (rx_stb) begin
            n_stb++;
            last_stb = rx_dat;
        end
        if (rx_err) n_errp++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bit(input bit b, input int hp, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            cyc(5);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(hp - 8);
        end else begin
            cyc(hp);
        end
        ps2_clk = 1'b0;
        cyc(hp);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int from, input int to,
                             input int hp, input int glitch_idx);
        for (int i = from; i <= to; i++) send_bit(f[i], hp, i == glitch_idx);
    endtask

    task automatic send_frame(input logic [10:0] f, input int hp, input int glitch_idx);
        send_bits(f, 0, 10, hp, glitch_idx);
        ps2_dat = 1'b1;
        cyc(2 * hp);
    endtask

    int s0, e0, exp_good, exp_bad;

    initial begin
        cyc(5);
        check("rst_dat", rx_dat, 8'h00);
        check("rst_stb", rx_stb, 1'b0);
        check("rst_err", rx_err, 1'b0);
        rst = 1'b0;
        cyc(20);

        s0 = n_stb; e0 = n_errp;
        send_frame(mk_frame(8'h1C, 0, 1), 40, -1);
        check("f1c_cnt", n_stb - s0, 1);
        check("f1c_dat", last_stb, 8'h1C);
        check("f1c_err", n_errp - e0, 0);

        s0 = n_stb;
        send_frame(mk_frame(8'hF0, 0, 1), 40, -1);
        check("ff0_dat", last_stb, 8'hF0);
        send_frame(mk_frame(8'h1C, 0, 1), 40, -1);
        check("ff0_1c_dat", last_stb, 8'h1C);
        check("ff0_1c_cnt", n_stb - s0, 2);

        s0 = n_stb; e0 = n_errp;
        send_frame(mk_frame(8'h1C, 1, 1), 40, -1);
        check("badpar_err", n_errp - e0, 1);
        check("badpar_stb", n_stb - s0, 0);
        check("badpar_hold", rx_dat, 8'h1C);
        send_frame(mk_frame(8'h29, 0, 1), 40, -1);
        check("after_bad_dat", last_stb, 8'h29);

        s0 = n_stb; e0 = n_errp;
        ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(30);
        send_frame(mk_frame(8'h74, 0, 1), 40, 4);
        check("glitch_cnt", n_stb - s0, 1);
        check("glitch_dat", last_stb, 8'h74);
        check("glitch_err", n_errp - e0, 0);

        s0 = n_stb; e0 = n_errp;
        send_frame(mk_frame(8'h5A, 0, 0), 40, -1);
        check("stop0_err", n_errp - e0, 1);
        check("stop0_stb", n_stb - s0, 0);

        s0 = n_stb; e0 = n_errp;
        send_bits(mk_frame(8'h6B, 0, 1), 0, 4, 40, -1);
        cyc(TO + 500);
`ifdef FPGA_ROBOTS_PS2_WATCHDOG_EN
        check("wd_err", n_errp - e0, 1);
        check("wd_stb", n_stb - s0, 0);
        ps2_dat = 1'b1;
        cyc(40);
        send_frame(mk_frame(8'h29, 0, 1), 40, -1);
        check("wd_next_dat", last_stb, 8'h29);
        check("wd_next_cnt", n_stb - s0, 1);
`else
        check("nowd_err", n_errp - e0, 0);
        send_bits(mk_frame(8'h6B, 0, 1), 5, 10, 40, -1);
        ps2_dat = 1'b1;
        cyc(80);
        check("nowd_dat", last_stb, 8'h6B);
        check("nowd_cnt", n_stb - s0, 1);
`endif

        s0 = n_stb; e0 = n_errp;
        send_bits(mk_frame(8'h33, 0, 1), 0, 4, 40, -1);
        ps2_dat = 1'b1;
        rst = 1'b1;
        cyc(4);
        rst = 1'b0;
        cyc(20);
        check("rst_mid_stb", n_stb - s0, 0);
        check("rst_mid_err", n_errp - e0, 0);
        check("rst_mid_dat", rx_dat, 8'h00);
        send_frame(mk_frame(8'h1C, 0, 1), 40, -1);
        check("rst_next_dat", last_stb, 8'h1C);

        s0 = n_stb; e0 = n_errp;
        exp_good = 0; exp_bad = 0;
        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            bit         bp, st;
            int         hp, gi;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 4) == 0);
            st = ($urandom_range(0, 5) != 0);
            hp = int'($urandom_range(30, 50));
            gi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            if (!bp && st) exp_good++; else exp_bad++;
            send_frame(mk_frame(d, bp, st), hp, gi);
        end
        check("rand_stb_cnt", n_stb - s0, exp_good);
        check("rand_err_cnt", n_errp - e0, exp_bad);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
